si5340_cfg_sequencer: RTL and testbench

SI5340_CFG_SEQUENCER -- requirements
Module: si5340_cfg_sequencer

---
 rtl/cfg_pkg.sv | 34 +++
 rtl/si5340_cfg_sequencer_if.sv | 36 +++
 rtl/si5340_i2c_txn.sv | 96 +++++++++
 rtl/si5340_cfg_sequencer.sv | 167 ++++++++++++++++
 tb/tb_si5340_cfg_sequencer.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_pkg.sv
// Shared types and defaults for the Si5340 configuration loader.
// Entry layout is {page[23:16], reg[15:8], data[7:0]}.
package cfg_pkg;

    localparam int         MEM_DEPTH  = 326;
    localparam int         MEM_WIDTH  = 24;
    localparam int         DATA_WIDTH = 8;
    localparam logic [6:0] SLAVE_ADDR = 7'b111_0100;
    localparam logic [7:0] PAGE_REG   = 8'h01;

    typedef enum logic {
        WRITE = 1'b0,
        READ  = 1'b1
    } r_w_e;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WAIT_MEM,
        PAGE_TX,
        REG_TX,
        DELAY,
        NEXT,
        DONE,
        ERROR
    } state_e;

    typedef enum logic [1:0] {
        T_IDLE,
        T_SEND,
        T_WAIT
    } txn_state_e;

endpackage

// File: rtl/si5340_cfg_sequencer_if.sv
// Config-memory read port plus byte-wide I2C command/response channel.
// Signal names are from the sequencer's point of view (master modport).
interface si5340_cfg_sequencer_if #(
    parameter int MEM_DEPTH  = cfg_pkg::MEM_DEPTH,
    parameter int MEM_WIDTH  = cfg_pkg::MEM_WIDTH,
    parameter int DATA_WIDTH = cfg_pkg::DATA_WIDTH
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic                  mem_rd_o;
    logic [AW-1:0]         mem_addr_o;
    logic [MEM_WIDTH-1:0]  mem_data_i;

    logic                  i2c_cmd_valid_o;
    logic                  i2c_cmd_ready_i;
    logic [DATA_WIDTH-1:0] i2c_cmd_data_o;
    logic                  i2c_cmd_start_o;
    logic                  i2c_cmd_stop_o;
    logic                  i2c_rsp_valid_i;
    logic                  i2c_rsp_nack_i;

    modport master (
        output mem_rd_o, mem_addr_o,
        input  mem_data_i,
        output i2c_cmd_valid_o, i2c_cmd_data_o, i2c_cmd_start_o, i2c_cmd_stop_o,
        input  i2c_cmd_ready_i, i2c_rsp_valid_i, i2c_rsp_nack_i
    );

    modport slave (
        input  mem_rd_o, mem_addr_o,
        output mem_data_i,
        input  i2c_cmd_valid_o, i2c_cmd_data_o, i2c_cmd_start_o, i2c_cmd_stop_o,
        output i2c_cmd_ready_i, i2c_rsp_valid_i, i2c_rsp_nack_i
    );

endinterface

// File: rtl/si5340_i2c_txn.sv
// One 3-byte I2C write: {addr,W}, byte1, byte2; start on byte 0, stop on byte 2.
// Latency: one cmd per byte, next byte only after the previous byte's response.
// Backpressure: cmd_valid_o holds data/flags until cmd_ready_i; a NACK aborts the rest.
module si5340_i2c_txn #(
    parameter logic [6:0] SLAVE_ADDR = cfg_pkg::SLAVE_ADDR,
    parameter int         DATA_WIDTH = cfg_pkg::DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  go_i,
    input  logic [DATA_WIDTH-1:0] byte1_i,
    input  logic [DATA_WIDTH-1:0] byte2_i,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [DATA_WIDTH-1:0] cmd_data_o,
    output logic                  cmd_start_o,
    output logic                  cmd_stop_o,
    input  logic                  rsp_valid_i,
    input  logic                  rsp_nack_i,
    output logic                  ok_o,
    output logic                  nack_o
);
    import cfg_pkg::*;

    localparam logic [DATA_WIDTH-1:0] ADDR_BYTE = {SLAVE_ADDR, WRITE};

    txn_state_e            state_q;
    logic [1:0]            idx_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  start_q;
    logic                  stop_q;
    logic                  ok_q;
    logic                  nack_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= T_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            ok_q    <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            ok_q   <= 1'b0;
            nack_q <= 1'b0;
            case (state_q)
                T_IDLE: begin
                    if (go_i) begin
                        valid_q <= 1'b1;
                        data_q  <= ADDR_BYTE;
                        start_q <= 1'b1;
                        stop_q  <= 1'b0;
                        idx_q   <= 2'd0;
                        state_q <= T_SEND;
                    end
                end
                T_SEND: begin
                    if (cmd_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= T_WAIT;
                    end
                end
                T_WAIT: begin
                    if (rsp_valid_i) begin
                        if (rsp_nack_i || idx_q == 2'd2) begin
                            nack_q  <= rsp_nack_i;
                            ok_q    <= !rsp_nack_i;
                            start_q <= 1'b0;
                            stop_q  <= 1'b0;
                            state_q <= T_IDLE;
                        end else begin
                            valid_q <= 1'b1;
                            data_q  <= (idx_q == 2'd0) ? byte1_i : byte2_i;
                            start_q <= 1'b0;
                            stop_q  <= (idx_q == 2'd1);
                            idx_q   <= idx_q + 2'd1;
                            state_q <= T_SEND;
                        end
                    end
                end
                default: state_q <= T_IDLE;
            endcase
        end
    end

    assign cmd_valid_o = valid_q;
    assign cmd_data_o  = data_q;
    assign cmd_start_o = start_q;
    assign cmd_stop_o  = stop_q;
    assign ok_o        = ok_q;
    assign nack_o      = nack_q;

endmodule

// File: rtl/si5340_cfg_sequencer.sv
// Streams the Si5340 register table to I2C with page switching, NACK retry and a post-preamble delay.
// Latency: 2 cycles fetch per entry plus one or two 3-byte transactions; DELAY_CYCLES after the preamble.
// Backpressure: stalls on i2c_cmd_ready_i and response; SI5340_PAGE_CACHE_EN skips redundant page writes.
module si5340_cfg_sequencer #(
    parameter int          MEM_DEPTH    = cfg_pkg::MEM_DEPTH,
    parameter int          MEM_WIDTH    = cfg_pkg::MEM_WIDTH,
    parameter int          DATA_WIDTH   = cfg_pkg::DATA_WIDTH,
    parameter logic [6:0]  SLAVE_ADDR   = cfg_pkg::SLAVE_ADDR,
    parameter int          PREAMBLE_LEN = 3,
    parameter int unsigned DELAY_CYCLES = 37_500_000,
    parameter int          MAX_RETRY    = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    si5340_cfg_sequencer_if.master bus
);
    import cfg_pkg::*;

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`ifdef SI5340_PAGE_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    state_e                state_q;
    logic [AW-1:0]         index_q;
    logic [RW-1:0]         retry_q;
    logic                  cache_vld_q;
    logic [7:0]            cache_page_q;
    logic [MEM_WIDTH-1:0]  entry_q;
    logic [31:0]           delay_q;
    logic                  go_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic                  mem_rd_q;

    logic                  page_tx_d;
    logic [DATA_WIDTH-1:0] txn_b1_d;
    logic [DATA_WIDTH-1:0] txn_b2_d;
    logic                  txn_ok;
    logic                  txn_nack;

    // Page compare uses the memory word directly so the decision is ready in WAIT_MEM.
    assign page_tx_d = !(CACHE_EN && cache_vld_q && (bus.mem_data_i[23:16] == cache_page_q));
    assign txn_b1_d  = (state_q == PAGE_TX) ? PAGE_REG : entry_q[15:8];
    assign txn_b2_d  = (state_q == PAGE_TX) ? entry_q[23:16] : entry_q[7:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            index_q      <= '0;
            retry_q      <= '0;
            cache_vld_q  <= 1'b0;
            cache_page_q <= '0;
            entry_q      <= '0;
            delay_q      <= '0;
            go_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            mem_rd_q     <= 1'b0;
        end else begin
            go_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start_i) begin
                        index_q     <= '0;
                        retry_q     <= '0;
                        cache_vld_q <= 1'b0;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        mem_rd_q    <= 1'b1;
                        state_q     <= FETCH;
                    end
                end
                FETCH: begin
                    mem_rd_q <= 1'b0;
                    state_q  <= WAIT_MEM;
                end
                WAIT_MEM: begin
                    entry_q <= bus.mem_data_i;
                    go_q    <= 1'b1;
                    state_q <= page_tx_d ? PAGE_TX : REG_TX;
                end
                PAGE_TX, REG_TX: begin
                    if (txn_nack) begin
                        if (retry_q == RW'(MAX_RETRY)) begin
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                            state_q <= ERROR;
                        end else begin
                            retry_q <= retry_q + RW'(1);
                            go_q    <= 1'b1;
                        end
                    end else if (txn_ok) begin
                        retry_q <= '0;
                        if (state_q == PAGE_TX) begin
                            cache_vld_q  <= 1'b1;
                            cache_page_q <= entry_q[23:16];
                            go_q         <= 1'b1;
                            state_q      <= REG_TX;
                        end else if (index_q == AW'(PREAMBLE_LEN - 1)) begin
                            delay_q <= '0;
                            state_q <= DELAY;
                        end else begin
                            state_q <= NEXT;
                        end
                    end
                end
                DELAY: begin
                    if (delay_q + 32'd1 >= DELAY_CYCLES) begin
                        state_q <= NEXT;
                    end else begin
                        delay_q <= delay_q + 32'd1;
                    end
                end
                NEXT: begin
                    if (index_q == AW'(MEM_DEPTH - 1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        index_q  <= index_q + AW'(1);
                        mem_rd_q <= 1'b1;
                        state_q  <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    si5340_i2c_txn #(
        .SLAVE_ADDR (SLAVE_ADDR),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_txn (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .go_i        (go_q),
        .byte1_i     (txn_b1_d),
        .byte2_i     (txn_b2_d),
        .cmd_valid_o (bus.i2c_cmd_valid_o),
        .cmd_ready_i (bus.i2c_cmd_ready_i),
        .cmd_data_o  (bus.i2c_cmd_data_o),
        .cmd_start_o (bus.i2c_cmd_start_o),
        .cmd_stop_o  (bus.i2c_cmd_stop_o),
        .rsp_valid_i (bus.i2c_rsp_valid_i),
        .rsp_nack_i  (bus.i2c_rsp_nack_i),
        .ok_o        (txn_ok),
        .nack_o      (txn_nack)
    );

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign bus.mem_rd_o   = mem_rd_q;
    assign bus.mem_addr_o = index_q;

endmodule

// File: tb/tb_si5340_cfg_sequencer.sv
// Bench for si5340_cfg_sequencer: table of load scenarios checked against a byte scoreboard,
// plus hand-written reset and delay sequences.
module tb_si5340_cfg_sequencer;

    localparam int MD  = 4;
    localparam int DLY = 100;
    localparam int MR  = 3;
`ifdef SI5340_PAGE_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    typedef struct {
        logic [7:0] dat;
        logic       st;
        logic       sp;
        logic       nack;
        int         entry;
    } rec_t;

    typedef struct {
        logic [3:0][23:0] mem;
        int               nack_entry;
        int               nack_byte;
        int               nack_cnt;
        logic             exp_done;
        logic             exp_err;
        logic [1:0]       exp_addr;
        int               exp_nbytes;
    } scen_t;

    logic clk = 1'b0;
    logic rst_i;
    logic start_i;
    logic busy_o;
    logic done_o;
    logic err_o;

    si5340_cfg_sequencer_if #(.MEM_DEPTH(MD)) bus ();

    si5340_cfg_sequencer #(
        .MEM_DEPTH    (MD),
        .PREAMBLE_LEN (3),
        .DELAY_CYCLES (DLY),
        .MAX_RETRY    (MR)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         nbytes  = 0;
    int         t_stop2 = -1;
    int         t_start3 = -1;
    rec_t       sb[$];
    logic [23:0] mem [MD];
    scen_t      tab [6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    function automatic scen_t mk(input logic [23:0] m0, m1, m2, m3, input int ne, nb, nc,
                                 input logic ed, ee, input logic [1:0] ea, input int nby);
        scen_t s;
        s.mem[0] = m0; s.mem[1] = m1; s.mem[2] = m2; s.mem[3] = m3;
        s.nack_entry = ne; s.nack_byte = nb; s.nack_cnt = nc;
        s.exp_done = ed; s.exp_err = ee; s.exp_addr = ea; s.exp_nbytes = nby;
        return s;
    endfunction

    // Reference stream: one record per byte the device should see, with the reply to give.
    task automatic push_txn(input logic [7:0] b1, input logic [7:0] b2, input int e,
                            input int ncnt, input int nbyte, output bit ok);
        logic [7:0] bt [3];
        rec_t r;
        bit nk;
        bt[0] = 8'hE8; bt[1] = b1; bt[2] = b2;
        ok = 1'b0;
        for (int a = 0; a <= MR && !ok; a++) begin
            nk = 1'b0;
            for (int b = 0; b < 3 && !nk; b++) begin
                r.dat = bt[b]; r.st = (b == 0); r.sp = (b == 2);
                r.nack = (a < ncnt) && (b == nbyte); r.entry = e;
                sb.push_back(r);
                nk = r.nack;
            end
            ok = !nk;
        end
    endtask

    task automatic build_exp(input scen_t s);
        logic [7:0] cpg;
        bit cv;
        bit ok;
        cv = 1'b0; cpg = 8'h00;
        for (int e = 0; e < MD; e++) begin
            if (!(CACHE && cv && cpg == s.mem[e][23:16])) begin
                push_txn(8'h01, s.mem[e][23:16], e, 0, 0, ok);
                cpg = s.mem[e][23:16];
                cv  = 1'b1;
            end
            push_txn(s.mem[e][15:8], s.mem[e][7:0], e,
                     (e == s.nack_entry) ? s.nack_cnt : 0, s.nack_byte, ok);
            if (!ok) return;
        end
    endtask

    // Memory: data appears one cycle after the read strobe, filler otherwise.
    initial begin
        logic       rd_seen;
        logic [1:0] a_seen;
        rd_seen = 1'b0; a_seen = 2'd0;
        bus.mem_data_i = 24'hA5A5A5;
        forever begin
            @(negedge clk);
            bus.mem_data_i = rd_seen ? mem[a_seen] : 24'hA5A5A5;
            rd_seen = bus.mem_rd_o;
            a_seen  = bus.mem_addr_o;
        end
    end

    // I2C target: random ready, response 1..3 cycles after acceptance.
    initial begin
        rec_t r;
        bit   rsp_pend;
        bit   rsp_nack_nxt;
        int   rsp_wait;
        rsp_pend = 1'b0; rsp_nack_nxt = 1'b0; rsp_wait = 0;
        bus.i2c_cmd_ready_i = 1'b0;
        bus.i2c_rsp_valid_i = 1'b0;
        bus.i2c_rsp_nack_i  = 1'b0;
        forever begin
            @(negedge clk);
            bus.i2c_rsp_valid_i = 1'b0;
            bus.i2c_rsp_nack_i  = 1'b0;
            if (rsp_pend) begin
                if (rsp_wait == 0) begin
                    bus.i2c_rsp_valid_i = 1'b1;
                    bus.i2c_rsp_nack_i  = rsp_nack_nxt;
                    rsp_pend = 1'b0;
                end else begin
                    rsp_wait--;
                end
            end
            bus.i2c_cmd_ready_i = ($urandom_range(0, 3) != 0);
            if (bus.i2c_cmd_valid_o && bus.i2c_cmd_ready_i) begin
                nbytes++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: got %02h, required no byte", bus.i2c_cmd_data_o);
                    rsp_nack_nxt = 1'b0;
                end else begin
                    r = sb.pop_front();
                    if ({bus.i2c_cmd_data_o, bus.i2c_cmd_start_o, bus.i2c_cmd_stop_o} !== {r.dat, r.st, r.sp}) begin
                        n_fail++;
                        $display("FAIL byte_e%0d: got %02h st=%0b sp=%0b, required %02h st=%0b sp=%0b",
                                 r.entry, bus.i2c_cmd_data_o, bus.i2c_cmd_start_o, bus.i2c_cmd_stop_o,
                                 r.dat, r.st, r.sp);
                    end
                    rsp_nack_nxt = r.nack;
                    if (r.sp && !r.nack && r.entry == 2) t_stop2 = cyc;
                    if (r.st && r.entry == 3 && t_start3 < 0) t_start3 = cyc;
                end
                rsp_pend = 1'b1;
                rsp_wait = $urandom_range(0, 2);
            end
        end
    end

    task automatic kick(input scen_t s, input string nm);
        for (int i = 0; i < MD; i++) mem[i] = s.mem[i];
        sb.delete();
        build_exp(s);
        nbytes = 0; t_stop2 = -1; t_start3 = -1;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        chk({nm, "_busy_after_start"}, busy_o, 1);
        chk({nm, "_done_cleared"}, done_o, 0);
        chk({nm, "_err_cleared"}, err_o, 0);
    endtask

    task automatic run_load(input scen_t s, input string nm);
        kick(s, nm);
        repeat (8) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        for (int k = 0; k < 20000 && !(done_o || err_o); k++) @(negedge clk);
        chk({nm, "_finished"}, done_o | err_o, 1);
        repeat (5) @(negedge clk);
        chk({nm, "_done"}, done_o, s.exp_done);
        chk({nm, "_err"}, err_o, s.exp_err);
        chk({nm, "_busy_end"}, busy_o, 0);
        chk({nm, "_bytes_left"}, sb.size(), 0);
        chk({nm, "_byte_count"}, nbytes, s.exp_nbytes);
        if (s.exp_err) chk({nm, "_err_addr"}, bus.mem_addr_o, s.exp_addr);
    endtask

    initial begin
        tab[0] = mk(24'h000B24, 24'h000B25, 24'h010A01, 24'h010A02, -1, 0, 0,  1, 0, 2'd0, CACHE ? 18 : 24);
        tab[1] = mk(24'h000B24, 24'h000B25, 24'h010A01, 24'h010A02,  2, 1, 1,  1, 0, 2'd0, CACHE ? 20 : 26);
        tab[2] = mk(24'h000B24, 24'h000B25, 24'h010A01, 24'h010A02,  1, 0, 99, 0, 1, 2'd1, CACHE ? 10 : 13);
        tab[3] = mk(24'h000B24, 24'h000B25, 24'h010A01, 24'h010A02,  0, 2, 3,  1, 0, 2'd0, CACHE ? 27 : 33);
        tab[4] = mk(24'h000B24, 24'h000B25, 24'h010A01, 24'h010A02,  3, 0, 4,  0, 1, 2'd3, CACHE ? 19 : 25);
        tab[5] = mk(24'h010011, 24'h010022, 24'h030033, 24'h010044, -1, 0, 0,  1, 0, 2'd0, CACHE ? 21 : 24);

        rst_i = 1'b1; start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy_o, done_o, err_o, bus.mem_rd_o, bus.i2c_cmd_valid_o,
                              bus.i2c_cmd_start_o, bus.i2c_cmd_stop_o}, 0);
        chk("reset_addr", bus.mem_addr_o, 0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_load(tab[i], $sformatf("scen%0d", i));
            if (i == 0) chk("delay_gap_ge_100", (t_start3 - t_stop2) >= DLY, 1);
        end

        // Reset while counting the post-preamble delay.
        kick(tab[0], "rst_delay");
        for (int k = 0; k < 5000 && t_stop2 < 0; k++) @(negedge clk);
        chk("rst_reach_entry2_stop", t_stop2 >= 0, 1);
        repeat (30) @(negedge clk);
        chk("rst_in_delay_busy", busy_o, 1);
        chk("rst_in_delay_no_entry3", t_start3, -1);
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {busy_o, done_o, err_o, bus.mem_rd_o, bus.i2c_cmd_valid_o,
                                bus.i2c_cmd_start_o, bus.i2c_cmd_stop_o}, 0);
        chk("rst_mid_addr", bus.mem_addr_o, 0);
        rst_i = 1'b0;
        nbytes = 0;
        repeat (20) @(negedge clk);
        chk("rst_stays_idle", busy_o, 0);
        chk("rst_no_bytes", nbytes, 0);
        run_load(tab[0], "reload");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
